// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a small input FIFO
// Frames are start, DATA_BITS LSB first, optional parity, STOP_BITS stops; each bit lasts DIV clocks.
module uart_tx_param #(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [DATA_BITS-1:0]          data,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam logic [AW:0]   FULL   = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t state, state_nxt;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] head, tail;
  logic [DATA_BITS-1:0] shift;
  logic [CW-1:0] div;
  logic [2:0] bit_cnt;
  logic par, push, pop, tick, last;
  assign tick = div == '0;
  assign last = bit_cnt == '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pop) state_nxt = S_START;
      S_START: if (tick) state_nxt = S_DATA;
      S_DATA:  if (tick && last) state_nxt = PARITY != 0 ? S_PAR : S_STOP;
      S_PAR:   if (tick) state_nxt = S_STOP;
      S_STOP:  if (tick && last) state_nxt = pop ? S_START : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
  // Pop either from idle or on the final stop edge, giving gapless back-to-back frames.
  always_comb begin
    ready = level != FULL;
    push  = start && ready;
    pop   = level != '0 && (state == S_IDLE || (state == S_STOP && tick && last));
    busy  = state != S_IDLE || level != '0;
  end
  always_ff @(posedge clk)
    if (push) mem[tail] <= data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      head    <= '0;
      tail    <= '0;
      level   <= '0;
      shift   <= '0;
      par     <= 1'b0;
      div     <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (pop) begin
        shift <= mem[head];
        par   <= ^mem[head] ^ (PARITY == 1);
        tx    <= 1'b0;
        div   <= RELOAD;
      end else if (state != S_IDLE) begin
        div <= tick ? RELOAD : div - 1'b1;
        if (tick)
          case (state)
            S_START: begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= 3'(DATA_BITS - 1);
            end
            S_DATA: if (last) begin
              tx      <= PARITY != 0 ? par : 1'b1;
              bit_cnt <= 3'(STOP_BITS - 1);
            end else begin
              tx      <= shift[0];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt - 1'b1;
            end
            S_PAR:  tx <= 1'b1;
            S_STOP: if (!last) bit_cnt <= bit_cnt - 1'b1;
            default: ;
          endcase
      end
    end
endmodule
